// File: rtl/matrix_mac_engine.sv
// Sequential N x N matrix multiplier: one multiply-accumulate per cycle, result held until consumed.
// Optional macro MATRIX_MAC_SIGNED_EN selects two's-complement operands and results.
module matrix_mac_engine #(
    parameter int unsigned BIT_SIZE       = 8,
    parameter int unsigned ROW_COL_SIZE   = 3,
    parameter int unsigned OUT_M_BIT_SIZE = 2*BIT_SIZE + $clog2(ROW_COL_SIZE)
) (
    input  logic                                                 clk,
    input  logic                                                 n_rst,
    input  logic                                                 in_valid,
    output logic                                                 in_ready,
    input  logic [0:BIT_SIZE*ROW_COL_SIZE*ROW_COL_SIZE-1]        m1,
    input  logic [0:BIT_SIZE*ROW_COL_SIZE*ROW_COL_SIZE-1]        m2,
    output logic                                                 out_valid,
    input  logic                                                 out_ready,
    output logic [0:OUT_M_BIT_SIZE*ROW_COL_SIZE*ROW_COL_SIZE-1]  out_m,
    output logic                                                 busy
);

    localparam int unsigned N     = ROW_COL_SIZE;
    localparam int unsigned OW    = OUT_M_BIT_SIZE;
    localparam int unsigned IN_W  = BIT_SIZE*N*N;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N-1);

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    state_t               state, state_nxt;
    logic [0:IN_W-1]      op_a, op_b;
    logic [IDX_W-1:0]     k, l, a;
    logic [OW-1:0]        acc, prod, mac_sum;
    logic [BIT_SIZE-1:0]  elem_a, elem_b;
    logic                 row_end, last_mac;

    assign row_end  = (a == LAST);
    assign last_mac = row_end && (l == LAST) && (k == LAST);

    // Operand fetch and single multiply-accumulate for the current (k, l, a)
    always_comb begin
        elem_a  = op_a[(int'(k)*N + int'(a))*BIT_SIZE +: BIT_SIZE];
        elem_b  = op_b[(int'(a)*N + int'(l))*BIT_SIZE +: BIT_SIZE];
`ifdef MATRIX_MAC_SIGNED_EN
        prod    = OW'($signed(elem_a)) * OW'($signed(elem_b));
`else
        prod    = OW'(elem_a) * OW'(elem_b);
`endif
        mac_sum = acc + prod;
    end

    always_ff @(posedge clk) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = COMPUTE;
            COMPUTE: if (last_mac)  state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Handshake flags registered from the next state so they track state exactly
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            in_ready  <= (state_nxt == IDLE);
            out_valid <= (state_nxt == DONE);
            busy      <= (state_nxt == COMPUTE);
        end
    end

    // Operand capture, index walk (a innermost, then l, then k) and result write-back
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            op_a  <= '0;
            op_b  <= '0;
            k     <= '0;
            l     <= '0;
            a     <= '0;
            acc   <= '0;
            out_m <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a <= m1;
                        op_b <= m2;
                        k    <= '0;
                        l    <= '0;
                        a    <= '0;
                        acc  <= '0;
                    end
                end
                COMPUTE: begin
                    if (row_end) begin
                        out_m[(int'(k)*N + int'(l))*OW +: OW] <= mac_sum;
                        acc <= '0;
                        a   <= '0;
                        if (l == LAST) begin
                            l <= '0;
                            k <= (k == LAST) ? '0 : k + IDX_W'(1);
                        end else begin
                            l <= l + IDX_W'(1);
                        end
                    end else begin
                        acc <= mac_sum;
                        a   <= a + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_mac_engine.sv
// Directed bench for matrix_mac_engine: a 3x3 instance and a 1x1 instance with hand-computed results.
module tb_matrix_mac_engine;

    localparam int unsigned OW3 = 18;
    localparam int unsigned OW1 = 16;

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    logic              in_valid, in_ready, out_valid, out_ready, busy;
    logic [0:71]       m1, m2;
    logic [0:OW3*9-1]  out_m;

    logic              in_valid1, in_ready1, out_valid1, out_ready1, busy1;
    logic [0:7]        m1_1, m2_1;
    logic [0:OW1-1]    out_m1;

    int total = 0;
    int bad   = 0;

    matrix_mac_engine #(.BIT_SIZE(8), .ROW_COL_SIZE(3)) dut (
        .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready),
        .m1(m1), .m2(m2), .out_valid(out_valid), .out_ready(out_ready),
        .out_m(out_m), .busy(busy)
    );

    matrix_mac_engine #(.BIT_SIZE(8), .ROW_COL_SIZE(1)) dut1 (
        .clk(clk), .n_rst(n_rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .m1(m1_1), .m2(m2_1), .out_valid(out_valid1), .out_ready(out_ready1),
        .out_m(out_m1), .busy(busy1)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [0:71] pack3(input int v [9]);
        logic [0:71] r;
        for (int i = 0; i < 9; i++) r[i*8 +: 8] = 8'(v[i]);
        return r;
    endfunction

    task automatic check3(input string tag, input int e [9]);
        logic [OW3-1:0] ev;
        logic [OW3-1:0] gv;
        for (int i = 0; i < 9; i++) begin
            ev = OW3'(e[i]);
            gv = out_m[i*OW3 +: OW3];
            chk($sformatf("%s_c%0d", tag, i), 64'(gv), 64'(ev));
        end
    endtask

    // Accept one operand pair, optionally disturbing inputs while computing, and measure latency
    task automatic run3(input logic [0:71] a_v, input logic [0:71] b_v, input bit disturb, output int lat);
        m1 = a_v;
        m2 = b_v;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        chk("busy_after_accept", 64'(busy), 64'(1));
        lat = 0;
        while (!out_valid && lat < 200) begin
            if (disturb) begin
                in_valid = 1'b1;
                m1 = ~a_v;
                m2 = ~b_v;
            end
            tick;
            lat++;
        end
        in_valid = 1'b0;
    endtask

    task automatic release3;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chk("release_in_ready", 64'(in_ready), 64'(1));
        chk("release_out_valid", 64'(out_valid), 64'(0));
    endtask

    initial begin
        int va [9];
        int vb [9];
        int ve [9];
        int lat;
        logic [0:OW3*9-1] snap;
        logic [OW1-1:0]   e1;

        n_rst = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; m1 = '0; m2 = '0;
        in_valid1 = 1'b0; out_ready1 = 1'b0; m1_1 = '0; m2_1 = '0;
        tick;
        tick;
        n_rst = 1'b1;
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_out_m_zero", 64'(out_m == '0), 64'(1));
        chk("rst1_in_ready", 64'(in_ready1), 64'(1));
        chk("rst1_out_m", 64'(out_m1), 64'(0));

        // Identity times 1..9
        va = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
        vb = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        run3(pack3(va), pack3(vb), 1'b0, lat);
        chk("ident_latency", 64'(lat), 64'(27));
        check3("ident", vb);

        // Consumer stall: everything holds while out_ready is low
        snap = out_m;
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("stall_out_valid", 64'(out_valid), 64'(1));
            chk("stall_in_ready", 64'(in_ready), 64'(0));
            chk("stall_out_m_hold", 64'(out_m == snap), 64'(1));
        end
        release3;

        // General product with inputs toggled and in_valid held during COMPUTE
        va = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        vb = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
        ve = '{30, 24, 18, 84, 69, 54, 138, 114, 90};
        run3(pack3(va), pack3(vb), 1'b1, lat);
        chk("disturb_latency", 64'(lat), 64'(27));
        check3("disturb", ve);
        release3;

`ifdef MATRIX_MAC_SIGNED_EN
        va = '{-128, -128, -128, -128, -128, -128, -128, -128, -128};
        ve = '{49152, 49152, 49152, 49152, 49152, 49152, 49152, 49152, 49152};
        run3(pack3(va), pack3(va), 1'b0, lat);
        check3("neg_full", ve);
        release3;
        va = '{-1, -1, -1, -1, -1, -1, -1, -1, -1};
        vb = '{2, 2, 2, 2, 2, 2, 2, 2, 2};
        ve = '{-6, -6, -6, -6, -6, -6, -6, -6, -6};
        run3(pack3(va), pack3(vb), 1'b0, lat);
        check3("neg_small", ve);
        release3;
`else
        va = '{255, 255, 255, 255, 255, 255, 255, 255, 255};
        ve = '{195075, 195075, 195075, 195075, 195075, 195075, 195075, 195075, 195075};
        run3(pack3(va), pack3(va), 1'b0, lat);
        check3("full_range", ve);
        release3;
`endif

        // Reset at cycle 12 of COMPUTE, then a clean run
        va = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        vb = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
        m1 = pack3(va);
        m2 = pack3(vb);
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        for (int i = 0; i < 11; i++) tick;
        n_rst = 1'b0;
        tick;
        n_rst = 1'b1;
        chk("abort_out_m_zero", 64'(out_m == '0), 64'(1));
        chk("abort_in_ready", 64'(in_ready), 64'(1));
        chk("abort_busy", 64'(busy), 64'(0));
        ve = '{30, 24, 18, 84, 69, 54, 138, 114, 90};
        run3(pack3(va), pack3(vb), 1'b0, lat);
        chk("post_abort_latency", 64'(lat), 64'(27));
        check3("post_abort", ve);
        release3;

        // 1x1 instance: single-cycle compute
        m1_1 = 8'd13;
        m2_1 = 8'd11;
        in_valid1 = 1'b1;
        tick;
        in_valid1 = 1'b0;
        chk("n1_busy", 64'(busy1), 64'(1));
        lat = 0;
        while (!out_valid1 && lat < 50) begin tick; lat++; end
        chk("n1_latency", 64'(lat), 64'(1));
        chk("n1_prod_a", 64'(out_m1), 64'(143));
        out_ready1 = 1'b1;
        tick;
        out_ready1 = 1'b0;
        chk("n1_release_in_ready", 64'(in_ready1), 64'(1));

        m1_1 = 8'd200;
        m2_1 = 8'd3;
`ifdef MATRIX_MAC_SIGNED_EN
        e1 = 16'hFF58;
`else
        e1 = 16'd600;
`endif
        in_valid1 = 1'b1;
        tick;
        in_valid1 = 1'b0;
        lat = 0;
        while (!out_valid1 && lat < 50) begin tick; lat++; end
        chk("n1_latency_b", 64'(lat), 64'(1));
        chk("n1_prod_b", 64'(out_m1), 64'(e1));
        out_ready1 = 1'b1;
        tick;
        out_ready1 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
